// File: rtl/switch_conditioner_pkg.sv
// Shared constants and helpers for switch conditioning and other
// timing blocks that need a counter sized for a cycle count.
package switch_conditioner_pkg;

  // Default synchronizer depth per switch bit.
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Default number of stable cycles before a new level is accepted
  // (1 ms at 100 MHz).
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;

  // Width of a counter that must hold 0 .. max_count-1; never less than 1 bit.
  function automatic int unsigned counter_width(input int unsigned max_count);
    if (max_count <= 1) begin
      return 1;
    end
    return $clog2(max_count);
  endfunction

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: synchronizer chain, debounce counter, clean level flop
// and registered rise/fall strobes.
module debounce_bit
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);

  localparam int unsigned CNT_W = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_count;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;

  logic w_sync_out;
  logic w_mismatch;
  logic w_accept;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mismatch = w_sync_out ^ r_clean;
  // The new level is taken on the edge that would otherwise push the
  // counter past its last value, so the counter never wraps.
  assign w_accept   = w_mismatch && (r_count == CNT_LAST);

  // Plain flop chain to resolve metastability; nothing between stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Count consecutive cycles where the synchronized level differs from clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!w_mismatch || w_accept) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Update the clean level and emit the matching one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept & w_sync_out;
      r_fall <= w_accept & ~w_sync_out;
      if (w_accept) begin
        r_clean <= w_sync_out;
      end
    end
  end

  assign o_clean  = r_clean;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_accept = w_accept;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw board switches into a clean vector plus per-bit
// rise/fall strobes and a combined change strobe, all registered.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] w_accept;
  logic             r_changed;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce_bit (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (switches_raw[gi]),
        .o_clean  (switches_clean[gi]),
        .o_rise   (rise[gi]),
        .o_fall   (fall[gi]),
        .o_accept (w_accept[gi])
      );
    end
  endgenerate

  // Register the OR of the per-bit accept conditions so changed lines up
  // with the rise/fall flops instead of being decoded from them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_accept;
    end
  end

  assign changed = r_changed;

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-side stage that sits directly upstream of the CPU top's `switches` input and drives its 8-bit switch bus.
- Takes the raw, asynchronous board switches and passes each bit through a multi-flop synchronizer, then a per-bit debounce counter.
- Outputs a clean, glitch-free switch vector, plus single-cycle rise, fall and change strobes for memory-mapped I/O.
- Prevents metastability and switch bounce from reaching the data-memory I/O read path.

Parameters:
- WIDTH, 8, number of switch bits conditioned.
- SYNC_STAGES, 2, synchronizer flops per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a new level (1 ms at 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, shared with the CPU.
- rst_n  input  1  synchronous, active-low reset.
- switches_raw  input  WIDTH  asynchronous board switch levels.
- switches_clean  output  WIDTH  debounced levels; drives the CPU `switches` input.
- rise  output  WIDTH  one-cycle pulse per bit when its clean level goes 0->1.
- fall  output  WIDTH  one-cycle pulse per bit when its clean level goes 1->0.
- changed  output  1  one-cycle pulse, OR-reduction of (rise | fall).

Behaviour:
- Reset is synchronous and active-low:
  - Sampled only on the rising edge of clk while rst_n=0.
  - Clears all synchronizer flops, counters, switches_clean, rise, fall and changed to 0.
  - Takes priority over every other update.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit; sync_out is the last stage. No logic between the stages.
- Debounce, per bit, fully independent of the other bits:
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1 bit.
  - Each edge where sync_out == clean: counter <= 0.
  - Each edge where sync_out != clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - Each edge where sync_out != clean and counter == DEBOUNCE_CYCLES-1: clean <= sync_out, counter <= 0, and the matching rise/fall bit is asserted on the same edge.
- Latency: if raw holds a new level from before edge 1, switches_clean changes on edge SYNC_STAGES+DEBOUNCE_CYCLES. For SYNC_STAGES=2, DEBOUNCE_CYCLES=4, that is edge 6.
- Glitches: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive sync_out cycles resets the counter and never changes clean.
- DEBOUNCE_CYCLES=1: clean follows sync_out one edge later; the latency formula still holds.
- Strobes:
  - rise, fall and changed are registered, high for exactly one cycle and aligned with the clean update.
  - They are 0 in every other cycle.
  - Several bits may pulse in the same cycle.
- Reset mid-count discards the partial count. After rst_n deasserts, clean=0 and raw=1 needs the full latency again.
- Raw held at 1 through reset: after release it is accepted as a normal 0->1 edge and produces a rise pulse.
- No counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1.
- Outputs are purely registered, with no combinational path from switches_raw.

Decomposition:
- Shared package holds the default DEBOUNCE_CYCLES, default SYNC_STAGES, and a clog2-based counter-width function reused by other timing blocks (e.g. the LED refresh logic).
- One natural sub-module, debounce_bit:
  - Contains one bit's synchronizer chain, counter, clean flop and rise/fall flops.
  - switch_conditioner instantiates it WIDTH times in a generate loop and ORs the strobes into changed.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with raw=8'hFF -> switches_clean=8'h00, rise=fall=0, changed=0 throughout.
- Clean step (SYNC_STAGES=2, DEBOUNCE_CYCLES=4): raw 8'h00->8'h01 before edge 1:
  - switches_clean=8'h01 from edge 6.
  - rise=8'h01 and changed=1 for that cycle only.
- Bounce: raw bit3 toggles 1,0,1,0,1 every 2 cycles, then holds 1:
  - No change during the bouncing.
  - switches_clean[3]=1 exactly 6 edges after the final stable 1; exactly one rise pulse.
- Multi-bit: raw 8'hA5->8'h5A simultaneously -> one common edge with rise=8'h5A, fall=8'hA5, changed=1, switches_clean=8'h5A.
- Reset mid-count: raw=8'h80 held, rst_n=0 on edge 4 for one cycle -> clean stays 0, then updates 6 edges after release.
- Minimum glitch: a 3-cycle high pulse on raw bit0 with DEBOUNCE_CYCLES=4 -> switches_clean never changes and no strobes assert.
